// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared states, fault codes and funct3/opcode constants for lsu_ctrl
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_ILLEGAL  = 2'b10,
    FLT_TIMEOUT  = 2'b11
  } lsu_fault_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

  function automatic logic is_mem_opcode(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane replication / byte enables and load lane extraction
// Purely combinational; funct3[1:0] is the access size, funct3[2] selects zero-extension.
module lsu_lane_align import lsu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]                   i_f3,
  input  logic [$clog2(XLEN/8)-1:0]    i_off,
  input  logic [XLEN-1:0]              i_wdata,
  input  logic [XLEN-1:0]              i_rdata,
  output logic [XLEN/8-1:0]            o_web,
  output logic [XLEN-1:0]              o_di,
  output logic [XLEN-1:0]              o_ldata
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   w_mask;
  logic [XLEN-1:0] w_shifted;

  always_comb begin
    w_mask = '0;
    o_di   = i_wdata;
    case (i_f3[1:0])
      2'd0: begin
        w_mask = NB'(1);
        o_di   = {NB{i_wdata[7:0]}};
      end
      2'd1: begin
        w_mask = NB'(3);
        o_di   = {(NB/2){i_wdata[15:0]}};
      end
      2'd2: begin
        w_mask = NB'(15);
        o_di   = {(NB/4){i_wdata[31:0]}};
      end
      default: begin
        w_mask = '1;
        o_di   = i_wdata;
      end
    endcase
  end

  assign o_web = ~(w_mask << i_off);

  // Bring the addressed lane down to bit 0, then extend by access type.
  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_ldata = w_shifted;
    case (i_f3)
      F3_B:    o_ldata = XLEN'($signed(w_shifted[7:0]));
      F3_H:    o_ldata = XLEN'($signed(w_shifted[15:0]));
      F3_W:    o_ldata = XLEN'($signed(w_shifted[31:0]));
      F3_BU:   o_ldata = XLEN'(w_shifted[7:0]);
      F3_HU:   o_ldata = XLEN'(w_shifted[15:0]);
      F3_WU:   o_ldata = XLEN'(w_shifted[31:0]);
      default: o_ldata = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - multi-cycle load/store controller driving a wait-state SRAM port
// Define LSU_TIMEOUT_EN to add the ACCESS timeout fault (TIMEOUT_CYC cycles without mem_ack).
module lsu_ctrl import lsu_pkg::*; #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_cs,
  output logic                mem_oe,
  output logic [XLEN/8-1:0]   mem_web,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_di,
  input  logic [XLEN-1:0]     mem_do,
  input  logic                mem_ack,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic [1:0]          resp_fault
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  if ((XLEN != 32 && XLEN != 64) || ADDR_W < 3 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("lsu_ctrl: unsupported XLEN/ADDR_W/TIMEOUT_CYC");
  end

  lsu_state_t        r_state, w_next;
  lsu_fault_t        r_fault, w_dec_fault;
  logic              r_load;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata, r_rdata;
  logic              w_accept, w_f3_ok, w_illegal, w_misalign, w_timeout;
  logic [NB-1:0]     w_web;
  logic [XLEN-1:0]   w_di, w_ldata;

  assign w_accept = req_valid & req_ready;

  always_comb begin
    w_f3_ok = 1'b0;
    if (req_store)
      w_f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                (req_funct3 == F3_D && XLEN == 64);
    else
      w_f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                (req_funct3 == F3_BU) || (req_funct3 == F3_HU) ||
                ((req_funct3 == F3_D || req_funct3 == F3_WU) && XLEN == 64);
    w_illegal = (req_load == req_store) || !w_f3_ok;
    case (req_funct3[1:0])
      2'd1:    w_misalign = req_addr[0];
      2'd2:    w_misalign = req_addr[1:0] != 2'b00;
      2'd3:    w_misalign = req_addr[2:0] != 3'b000;
      default: w_misalign = 1'b0;
    endcase
    if (w_illegal)
      w_dec_fault = FLT_ILLEGAL;
    else if (w_misalign)
      w_dec_fault = FLT_MISALIGN;
    else
      w_dec_fault = FLT_NONE;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;

  // Held at zero outside ACCESS so every access starts a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (r_state != ACCESS)
      r_cnt <= '0;
    else if (!mem_ack)
      r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state == ACCESS) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .i_f3    (r_f3),
    .i_off   (r_addr[OFF_W-1:0]),
    .i_wdata (r_wdata),
    .i_rdata (mem_do),
    .o_web   (w_web),
    .o_di    (w_di),
    .o_ldata (w_ldata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    mem_cs     = 1'b0;
    mem_oe     = 1'b0;
    mem_web    = '1;
    mem_addr   = '0;
    mem_di     = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_fault = FLT_NONE;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          w_next = (w_dec_fault == FLT_NONE) ? ACCESS : RESP;
      end
      ACCESS: begin
        mem_cs   = 1'b1;
        mem_oe   = r_load;
        mem_web  = r_load ? '1 : w_web;
        mem_addr = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        mem_di   = r_load ? '0 : w_di;
        if (mem_ack || w_timeout)
          w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
        resp_fault = r_fault;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load  <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_fault <= FLT_NONE;
    end else if (w_accept) begin
      r_load  <= req_load;
      r_f3    <= req_funct3;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_rdata <= '0;
      r_fault <= w_dec_fault;
    end else if (r_state == ACCESS) begin
      if (mem_ack)
        r_rdata <= r_load ? w_ldata : '0;
      else if (w_timeout)
        r_fault <= FLT_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized self-checking bench for lsu_ctrl at XLEN 32 and 64
// Timeout scenarios run only when LSU_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_lsu_ctrl;

  localparam int TOUT = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;

  logic        v0, rdy0, cs0, oe0, ack0, rv0;
  logic [3:0]  web0;
  logic [31:0] addr0, di0, do0, rd0;
  logic [1:0]  f0;
  logic        v1, rdy1, cs1, oe1, ack1, rv1;
  logic [7:0]  web1;
  logic [31:0] addr1;
  logic [63:0] di1, do1, rd1;
  logic [1:0]  f1;

  lsu_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(TOUT)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .mem_cs(cs0), .mem_oe(oe0), .mem_web(web0), .mem_addr(addr0), .mem_di(di0), .mem_do(do0),
    .mem_ack(ack0), .resp_valid(rv0), .resp_rdata(rd0), .resp_fault(f0));

  lsu_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(TOUT)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_cs(cs1), .mem_oe(oe1), .mem_web(web1), .mem_addr(addr1), .mem_di(di1), .mem_do(do1),
    .mem_ack(ack1), .resp_valid(rv1), .resp_rdata(rd1), .resp_fault(f1));

  wire        a_ready [2];
  wire        a_cs    [2];
  wire        a_oe    [2];
  wire        a_rv    [2];
  wire [7:0]  a_web   [2];
  wire [31:0] a_addr  [2];
  wire [63:0] a_di    [2];
  wire [63:0] a_rdata [2];
  wire [1:0]  a_fault [2];
  assign a_ready[0] = rdy0;  assign a_ready[1] = rdy1;
  assign a_cs[0]    = cs0;   assign a_cs[1]    = cs1;
  assign a_oe[0]    = oe0;   assign a_oe[1]    = oe1;
  assign a_rv[0]    = rv0;   assign a_rv[1]    = rv1;
  assign a_web[0]   = {4'hF, web0};      assign a_web[1]   = web1;
  assign a_addr[0]  = addr0;             assign a_addr[1]  = addr1;
  assign a_di[0]    = {32'h0, di0};      assign a_di[1]    = di1;
  assign a_rdata[0] = {32'h0, rd0};      assign a_rdata[1] = rd1;
  assign a_fault[0] = f0;                assign a_fault[1] = f1;

  logic        e_ready [2];
  logic        e_cs    [2];
  logic        e_oe    [2];
  logic        e_rv    [2];
  logic [7:0]  e_web   [2];
  logic [31:0] e_addr  [2];
  logic [63:0] e_di    [2];
  logic [63:0] e_rdata [2];
  logic [1:0]  e_fault [2];

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  logic [7:0]  cap_web;
  logic [63:0] cap_di, cap_rdata;
  logic [1:0]  cap_fault;
  int          cap_cs_cnt, cap_rv_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic set_idle(input int d);
    e_ready[d] = 1'b1; e_cs[d] = 1'b0; e_oe[d] = 1'b0; e_rv[d] = 1'b0;
    e_web[d] = 8'hFF; e_addr[d] = 32'h0; e_di[d] = 64'h0; e_rdata[d] = 64'h0; e_fault[d] = 2'b00;
  endtask

  // Reference model: access size in bytes = 2**funct3[1:0], lane offset = addr mod lane count.
  function automatic logic [1:0] model_fault(input int xlen, input bit ld, input bit st,
                                             input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    int bytes;
    if (ld == st) return 2'b10;
    if (st) legal = (f3 <= 3'd2) || (f3 == 3'd3 && xlen == 64);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (xlen == 64 && f3 inside {3'd3, 3'd6});
    if (!legal) return 2'b10;
    bytes = 1 << f3[1:0];
    if (addr % bytes != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] model_web(input int nb, input logic [2:0] f3, input logic [31:0] addr);
    logic [7:0] w;
    int off, bytes;
    w = 8'hFF;
    off = addr % nb;
    bytes = 1 << f3[1:0];
    for (int i = 0; i < nb; i++)
      if (i >= off && i < off + bytes) w[i] = 1'b0;
    return w;
  endfunction

  function automatic logic [63:0] model_di(input int nb, input logic [2:0] f3, input logic [63:0] wd);
    logic [63:0] di;
    int bytes;
    di = 64'h0;
    bytes = 1 << f3[1:0];
    for (int i = 0; i < nb; i++)
      di[8*i +: 8] = wd[8*(i % bytes) +: 8];
    return di;
  endfunction

  function automatic logic [63:0] model_rdata(input int xlen, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [63:0] mdo);
    logic [63:0] v, m;
    int off, bits;
    off = addr % (xlen / 8);
    bits = 8 << f3[1:0];
    v = mdo >> (8 * off);
    if (bits < 64) begin
      m = (64'd1 << bits) - 64'd1;
      v = v & m;
      if (!f3[2] && v[bits-1]) v = v | ~m;
    end
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d_ready", d), 64'(a_ready[d]), 64'(e_ready[d]));
        chk($sformatf("d%0d_cs", d),    64'(a_cs[d]),    64'(e_cs[d]));
        chk($sformatf("d%0d_oe", d),    64'(a_oe[d]),    64'(e_oe[d]));
        chk($sformatf("d%0d_web", d),   64'(a_web[d]),   64'(e_web[d]));
        chk($sformatf("d%0d_addr", d),  64'(a_addr[d]),  64'(e_addr[d]));
        chk($sformatf("d%0d_di", d),    a_di[d],         e_di[d]);
        chk($sformatf("d%0d_rv", d),    64'(a_rv[d]),    64'(e_rv[d]));
        chk($sformatf("d%0d_rdata", d), a_rdata[d],      e_rdata[d]);
        chk($sformatf("d%0d_fault", d), 64'(a_fault[d]), 64'(e_fault[d]));
      end
    end
  end

  // Entered at posedge+1 with both DUTs idle; returns at posedge+1 with both idle again.
  task automatic do_req(input int d, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] mdo_in,
                        input int waits, input int rst_at);
    int nb, xlen, n, cyc;
    bit ack, tmo;
    logic [1:0] f;
    logic [63:0] mdo;
    xlen = (d == 0) ? 32 : 64;
    nb = xlen / 8;
    mdo = (d == 0) ? {32'h0, mdo_in[31:0]} : mdo_in;
    f = model_fault(xlen, ld, st, f3, addr);
    cap_web = 8'h0; cap_di = 64'h0; cap_rdata = 64'h0; cap_fault = 2'b00;
    cap_cs_cnt = 0; cap_rv_cyc = -1; cyc = 0; ack = 1'b0; tmo = 1'b0;
    req_load = ld; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (d == 0) v0 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    cyc++;
    v0 = 1'b0; v1 = 1'b0;
    e_ready[d] = 1'b0;
    if (f == 2'b00) begin
      e_cs[d] = 1'b1; e_oe[d] = ld;
      e_web[d] = st ? model_web(nb, f3, addr) : 8'hFF;
      e_addr[d] = addr - 32'(addr % nb);
      e_di[d] = st ? model_di(nb, f3, wd) : 64'h0;
      n = 0;
      forever begin
        ack = (n == waits);
        tmo = TO_EN && !ack && (n == TOUT - 1);
        if (d == 0) begin ack0 = ack; do0 = ack ? mdo[31:0] : $urandom; end
        else        begin ack1 = ack; do1 = ack ? mdo : {$urandom, $urandom}; end
        if (n == rst_at) begin
          #1 rst = 1'b0;
          #1 chk($sformatf("d%0d_async_cs_low", d), 64'(a_cs[d]), 64'd0);
          set_idle(0); set_idle(1);
          ack0 = 1'b0; ack1 = 1'b0;
          @(posedge clk); #1 rst = 1'b1;
          return;
        end
        if (a_cs[d]) cap_cs_cnt++;
        if (n == 0) begin cap_web = a_web[d]; cap_di = a_di[d]; end
        @(posedge clk); #1;
        cyc++; n++;
        if (ack || tmo) break;
      end
      ack0 = 1'b0; ack1 = 1'b0;
      e_cs[d] = 1'b0; e_oe[d] = 1'b0; e_web[d] = 8'hFF; e_addr[d] = 32'h0; e_di[d] = 64'h0;
      e_fault[d] = tmo ? 2'b11 : 2'b00;
      e_rdata[d] = (ack && ld) ? model_rdata(xlen, f3, addr, mdo) : 64'h0;
    end else begin
      e_fault[d] = f;
      e_rdata[d] = 64'h0;
    end
    e_rv[d] = 1'b1;
    if (a_cs[d]) cap_cs_cnt++;
    if (a_rv[d]) cap_rv_cyc = cyc;
    cap_rdata = a_rdata[d];
    cap_fault = a_fault[d];
    @(posedge clk); #1;
    set_idle(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          ld, st;
    int          d, kind, waits;
    rst = 1'b0;
    v0 = 1'b0; v1 = 1'b0; ack0 = 1'b0; ack1 = 1'b0; do0 = 32'h0; do1 = 64'h0;
    req_load = 1'b0; req_store = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 64'h0;
    set_idle(0); set_idle(1);
    #1 cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 64'(a_ready[0]), 64'd1);
    chk("reset_cs", 64'(a_cs[1]), 64'd0);
    chk("reset_web64", 64'(a_web[1]), 64'hFF);
    chk("reset_rv", 64'(a_rv[0]), 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    do_req(0, 1'b0, 1'b1, 3'b000, 32'h1003, 64'hA5, 64'h0, 0, -1);
    chk("sb_web", 64'(cap_web), 64'hF7);
    chk("sb_di", cap_di, 64'hA5A5_A5A5);
    chk("sb_resp_cycle", 64'(cap_rv_cyc), 64'd2);
    chk("sb_fault", 64'(cap_fault), 64'd0);

    do_req(0, 1'b1, 1'b0, 3'b001, 32'h2002, 64'h0, 64'h8001_1234, 3, -1);
    chk("lh_cs_cycles", 64'(cap_cs_cnt), 64'd4);
    chk("lh_rdata", cap_rdata, 64'hFFFF_8001);
    do_req(0, 1'b1, 1'b0, 3'b101, 32'h2002, 64'h0, 64'h8001_1234, 1, -1);
    chk("lhu_rdata", cap_rdata, 64'h0000_8001);

    do_req(0, 1'b1, 1'b0, 3'b010, 32'h2001, 64'h0, 64'h0, 0, -1);
    chk("lw_mis_cs", 64'(cap_cs_cnt), 64'd0);
    chk("lw_mis_resp_cycle", 64'(cap_rv_cyc), 64'd1);
    chk("lw_mis_fault", 64'(cap_fault), 64'd1);
    do_req(0, 1'b1, 1'b0, 3'b011, 32'h2000, 64'h0, 64'h0, 0, -1);
    chk("ld32_fault", 64'(cap_fault), 64'd2);

    do_req(1, 1'b0, 1'b1, 3'b011, 32'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 0, -1);
    chk("sd_web", 64'(cap_web), 64'h00);
    chk("sd_di", cap_di, 64'h0123_4567_89AB_CDEF);
    do_req(1, 1'b1, 1'b0, 3'b110, 32'h14, 64'h0, 64'hF000_0000_0000_0000, 0, -1);
    chk("lwu_rdata", cap_rdata, 64'h0000_0000_F000_0000);

    do_req(0, 1'b1, 1'b0, 3'b010, 32'h40, 64'h0, 64'hDEAD_BEEF, 3, 1);
    chk("rst_ready", 64'(a_ready[0]), 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_no_resp", 64'(a_rv[0]), 64'd0);
    end
    do_req(0, 1'b1, 1'b0, 3'b010, 32'h44, 64'h0, 64'h1234_5678, 0, -1);
    chk("post_rst_rdata", cap_rdata, 64'h1234_5678);

`ifdef LSU_TIMEOUT_EN
    do_req(0, 1'b1, 1'b0, 3'b010, 32'h3000, 64'h0, 64'h5555_AAAA, 100, -1);
    chk("tmo_fault", 64'(cap_fault), 64'd3);
    chk("tmo_rdata", cap_rdata, 64'h0);
    chk("tmo_cs_cycles", 64'(cap_cs_cnt), 64'd4);
    do_req(0, 1'b1, 1'b0, 3'b010, 32'h3000, 64'h0, 64'h5555_AAAA, 3, -1);
    chk("tmo_ack_wins_fault", 64'(cap_fault), 64'd0);
    chk("tmo_ack_wins_rdata", cap_rdata, 64'h5555_AAAA);
`endif

    for (int k = 0; k < 200; k++) begin
      d = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      ld = (kind < 5);
      st = (kind >= 5 && kind < 9);
      if (kind == 9) begin
        ld = 1'($urandom_range(0, 1));
        st = ld;
      end
      f3 = st ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(1 << f3[1:0]) - 32'd1);
      waits = int'($urandom_range(0, 3));
      do_req(d, ld, st, f3, addr, {$urandom, $urandom}, {$urandom, $urandom}, waits, -1);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Parametrised, multi-cycle load/store controller. Successor to the single-cycle combinational store-byte-enable and load-extend decode.
- Accepts one memory request from the EX/MEM stage through a valid/ready handshake and drives a wait-state-capable data SRAM port with active-low byte write enables.
- Returns an aligned, sign- or zero-extended load result, or a fault code.
- Supports XLEN 32 or 64 (RV64 LD/SD/LWU).

Parameters:
- XLEN, 32, data width; legal values 32 or 64; NB = XLEN/8 byte lanes.
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYC, 255, max ACCESS cycles before timeout fault (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_load  in  1  load request
- req_store  in  1  store request
- req_funct3  in  3  RISC-V funct3
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data (low bits significant)
- mem_cs  out  1  SRAM chip select
- mem_oe  out  1  SRAM read enable
- mem_web  out  NB  byte write enable, active-low (0 = write lane)
- mem_addr  out  ADDR_W  lane-aligned address (low log2(NB) bits zero)
- mem_di  out  XLEN  lane-replicated write data
- mem_do  in  XLEN  SRAM read data
- mem_ack  in  1  SRAM completes access this cycle
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults
- resp_fault  out  2  00 none, 01 misaligned, 10 illegal, 11 timeout

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- req_ready = 1 only in IDLE. Accept = req_valid & req_ready; all request fields are registered on accept.
- Decode is done at accept:
  - Illegal (fault 10): req_load == req_store (both set or neither); store funct3 not in {000,001,010,(011 if XLEN=64)}; load funct3 not in {000,001,010,100,101,(011,110 if XLEN=64)}.
  - Misaligned (fault 01): H with addr[0]=1; W with addr[1:0]≠0; D with addr[2:0]≠0.
  - Illegal takes priority over misaligned.
- Faulting request: IDLE→RESP directly; memory is never touched.
- Legal request: IDLE→ACCESS.
  - In ACCESS: mem_cs=1, mem_oe=req_load, mem_addr aligned.
  - Stores: mem_web has 0 on the addressed lanes only, 1 elsewhere. mem_di carries the byte replicated NB times, the half replicated NB/2 times, or the word replicated.
  - Loads: mem_web all 1.
  - Hold all memory outputs stable until mem_ack=1 is sampled, then →RESP.
- Load extraction on the ack cycle:
  - Select the lane(s) at the offset.
  - LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend; LD is passed through.
  - Result is registered into resp_rdata.
- RESP: resp_valid=1 for exactly one cycle (no backpressure), then →IDLE. The next request can be accepted the cycle after RESP.
- Minimum legal latency: accept at cycle N, ack at N+1, resp_valid at N+2.
- Outputs outside their active state: mem_cs=0, mem_oe=0, mem_web all 1, mem_addr/mem_di=0, resp_valid=0, resp_fault=00.
- Reset (rst=0), applied asynchronously at any time including mid-ACCESS:
  - FSM→IDLE; the in-flight access is abandoned with no response.
  - mem_cs=0 immediately; mem_web all 1; resp_*=0; req_ready=1.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An ACCESS cycle counter clears on entry to ACCESS.
  - If TIMEOUT_CYC cycles elapse without mem_ack: drop mem_cs, →RESP with fault 11, resp_rdata=0.
  - A mem_ack in the same cycle as expiry wins (normal completion).
- Undefined: ACCESS waits indefinitely; fault 11 is never produced; no counter logic is present.

Decomposition:
- Package lsu_pkg:
  - state enum (IDLE/ACCESS/RESP)
  - fault enum (FLT_NONE/FLT_MISALIGN/FLT_ILLEGAL/FLT_TIMEOUT)
  - funct3 constants F3_B/H/W/D/BU/HU/WU
  - opcode constants OP_LOAD=7'h03, OP_STORE=7'h23
- Sub-module lsu_lane_align (combinational, parametrised by XLEN):
  - store data replication and mem_web generation;
  - load lane selection and sign/zero extension.
- FSM, registers and timeout counter stay in lsu_ctrl.

Test Plan:
- XLEN=32, SB addr 0x1003 wdata 0xA5, ack after 0 waits → mem_web=4'b0111, mem_di=0xA5A5A5A5, resp_valid at N+2, fault 00.
- XLEN=32, LH addr 0x2002, mem_do=0x8001_1234, 3 wait cycles → mem_cs held 4 cycles; resp_rdata=0xFFFF8001. LHU at the same address → 0x00008001.
- XLEN=32, LW addr 0x2001 → no mem_cs, resp next cycle, fault 01. LD (funct3 011) → fault 10.
- XLEN=64, SD addr 0x10 → mem_web=8'h00. LWU addr 0x14, mem_do=0xF000_0000_0000_0000 (upper word 0xF0000000) → resp_rdata=0x00000000F0000000.
- Reset pulse during ACCESS → mem_cs low asynchronously; no resp_valid; req_ready=1 after release; next request completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYC=4, mem_ack never asserted → after 4 ACCESS cycles resp_valid with fault 11, resp_rdata=0. Ack on the 4th cycle → normal response.
